// File: rtl/reorder_buffer.sv
// reorder_buffer: allocates tags in order, accepts results in any order, and presents them for commit in allocation order.
module reorder_buffer #(
  parameter int ROB_DEPTH = 64,
  parameter int TW = $clog2(ROB_DEPTH),
  parameter int EW = 76
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          alloc_i,
  output logic [TW-1:0] alloc_tag_o,
  output logic          full_o,
  output logic          empty_o,
  input  logic          write_i,
  input  logic [TW-1:0] write_tag_i,
  input  logic [EW-1:0] write_entry_i,
  output logic          read_valid_o,
  output logic [EW-1:0] read_entry_o,
  input  logic          read_ack_i,
  input  logic          stall_i
);
  logic [TW-1:0] head, tail;
  logic [TW:0] count;
  logic [ROB_DEPTH-1:0] alloc_q, done_q;
  logic [EW-1:0] mem [ROB_DEPTH];
  logic do_alloc, do_write, do_ack;
  assign alloc_tag_o = tail;
  assign full_o = count == (TW+1)'(ROB_DEPTH);
  assign empty_o = count == '0;
  assign read_valid_o = alloc_q[head] & done_q[head] & !stall_i;
  assign read_entry_o = mem[head];
  assign do_alloc = alloc_i & !full_o;
  assign do_write = write_i & alloc_q[write_tag_i];
  assign do_ack = read_ack_i & read_valid_o;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i || flush_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      alloc_q <= '0;
      done_q <= '0;
    end else begin
      if (do_write) done_q[write_tag_i] <= 1'b1;
      if (do_ack) begin
        alloc_q[head] <= 1'b0;
        done_q[head] <= 1'b0;
        head <= head + 1'b1;
      end
      if (do_alloc) begin
        alloc_q[tail] <= 1'b1;
        done_q[tail] <= 1'b0;
        tail <= tail + 1'b1;
      end
      count <= count + (TW+1)'(do_alloc) - (TW+1)'(do_ack);
    end
  // Storage is not reset; an entry only becomes visible once its done bit is set.
  always_ff @(posedge clk_i)
    if (do_write) mem[write_tag_i] <= write_entry_i;
endmodule
